// File: rtl/sys_bus_ctrl_if.sv
// +----------------------------------------------------------------------------
// | sys_bus_ctrl_if : core-side and device-side bus signals of sys_bus_ctrl
// | Rev 1.0
// +----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface sys_bus_ctrl_if;
    logic         core_req_i;
    logic         core_we_i;
    logic [31:0]  core_addr_i;
    logic [31:0]  core_wdata_i;
    logic [31:0]  core_rdata_o;
    logic         core_stall_o;
    logic [7:0]   dev_req_o;
    logic         dev_we_o;
    logic [31:0]  dev_addr_o;
    logic [31:0]  dev_wdata_o;
    logic [255:0] dev_rdata_i;
    logic         bus_err_o;
    logic [31:0]  err_addr_o;
    logic [15:0]  err_cnt_o;

    // The controller is the slave; the core plus the device fabric form the master side.
    modport slave (
        input  core_req_i, core_we_i, core_addr_i, core_wdata_i, dev_rdata_i,
        output core_rdata_o, core_stall_o, dev_req_o, dev_we_o, dev_addr_o,
               dev_wdata_o, bus_err_o, err_addr_o, err_cnt_o
    );

    modport master (
        output core_req_i, core_we_i, core_addr_i, core_wdata_i, dev_rdata_i,
        input  core_rdata_o, core_stall_o, dev_req_o, dev_we_o, dev_addr_o,
               dev_wdata_o, bus_err_o, err_addr_o, err_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/sys_bus_ctrl.sv
// +----------------------------------------------------------------------------
// | sys_bus_ctrl : decodes core accesses onto up to 8 devices, logs unmapped hits
// | Rev 1.0
// +----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sys_bus_ctrl #(
    parameter logic [7:0] DEV_MASK = 8'h07
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    sys_bus_ctrl_if.slave bus
);
    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_RDATA = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [2:0]  sel_q, sel_d;
    logic        unm_q, unm_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic [7:0]  w_idx;
    logic [7:0]  w_onehot;
    logic        w_mapped;
    logic        w_unm_acc;
    logic [7:0]  w_dev_req;
    logic        w_stall;
    logic [31:0] w_rdata;

    assign w_idx     = bus.core_addr_i[31:24];
    assign w_mapped  = (w_idx < 8'd8) && DEV_MASK[w_idx[2:0]];
    assign w_onehot  = 8'b0000_0001 << w_idx[2:0];
    assign w_unm_acc = (state_q == c_IDLE) && bus.core_req_i && !w_mapped;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        unm_d   = unm_q;
        case (state_q)
            c_IDLE: begin
                if (bus.core_req_i && !bus.core_we_i) begin
                    state_d = c_RDATA;
                    sel_d   = w_idx[2:0];
                    unm_d   = !w_mapped;
                end
            end
            c_RDATA: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // Outputs are gated by rst_ni so a request held through reset cannot leak out.
    always_comb begin
        w_dev_req = 8'h00;
        w_stall   = 1'b0;
        w_rdata   = 32'h0;
        if (rst_ni) begin
            case (state_q)
                c_IDLE: begin
                    if (bus.core_req_i) begin
                        if (w_mapped) begin
                            w_dev_req = w_onehot & DEV_MASK;
                        end
                        w_stall = !bus.core_we_i;
                    end
                end
                c_RDATA: begin
                    if (!unm_q) begin
                        w_rdata = bus.dev_rdata_i[{sel_q, 5'b0_0000} +: 32];
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus_err_d  = w_unm_acc;
        err_addr_d = w_unm_acc ? bus.core_addr_i : err_addr_q;
        err_cnt_d  = (w_unm_acc && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_q      <= 3'd0;
            unm_q      <= 1'b0;
            bus_err_q  <= 1'b0;
            err_addr_q <= 32'h0;
            err_cnt_q  <= 16'h0;
        end else begin
            sel_q      <= sel_d;
            unm_q      <= unm_d;
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.dev_req_o    = w_dev_req;
    assign bus.core_stall_o = w_stall;
    assign bus.core_rdata_o = w_rdata;
    assign bus.dev_we_o     = bus.core_we_i;
    assign bus.dev_addr_o   = bus.core_addr_i;
    assign bus.dev_wdata_o  = bus.core_wdata_i;
    assign bus.bus_err_o    = bus_err_q;
    assign bus.err_addr_o   = err_addr_q;
    assign bus.err_cnt_o    = err_cnt_q;

endmodule

`default_nettype wire
